// File: rtl/flit_link_serializer.sv
// Outbound flit port: buffers 128-bit flits in a small FIFO and
// streams each one MSW-first as a burst of narrow link beats.
module flit_link_serializer #(
  parameter int FLIT_W = 128,
  parameter int LINK_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FLIT_W-1:0]        flit_in,
  input  logic                     flit_in_vld,
  output logic [LINK_W-1:0]        link_data,
  output logic                     link_vld,
  input  logic                     link_rdy,
  output logic                     link_sof,
  output logic                     link_eof,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int BEATS = FLIT_W / LINK_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [FLIT_W-1:0]  mem [DEPTH];
  logic [FLIT_W-1:0]  sreg;
  logic [BW-1:0]      beat;
  logic [AW:0]        wptr;
  logic [AW:0]        rptr;

  logic full;
  logic empty;
  logic push;
  logic drop;
  logic last_hs;
  logic pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // Fullness uses pre-edge state, so a same-edge pop never rescues a flit.
  assign push    = flit_in_vld && !full;
  assign drop    = flit_in_vld && full;
  assign last_hs = (state == SEND) && link_rdy && (beat == LAST);
  assign pop     = !empty && ((state == IDLE) || last_hs);

  assign link_vld   = (state == SEND);
  assign link_data  = sreg[FLIT_W-1 -: LINK_W];
  assign link_sof   = link_vld && (beat == '0);
  assign link_eof   = link_vld && (beat == LAST);
  assign fifo_level = wptr - rptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= flit_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wptr     <= wptr + (AW+1)'(push);
      rptr     <= rptr + (AW+1)'(pop);
      overflow <= drop;
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      beat  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            sreg  <= mem[rptr[AW-1:0]];
            beat  <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (link_rdy) begin
            if (beat == LAST) begin
              if (!empty) begin
                sreg <= mem[rptr[AW-1:0]];
                beat <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              sreg <= sreg << LINK_W;
              beat <= beat + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_link_serializer.sv
// Scoreboard bench: queue-based reference model predicts beats,
// occupancy and drops; a negedge monitor checks the link.
module tb_flit_link_serializer;

  localparam int FLIT_W = 128;
  localparam int LINK_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int BEATS  = FLIT_W / LINK_W;

  logic                    clk;
  logic                    rst_n;
  logic [FLIT_W-1:0]       flit_in;
  logic                    flit_in_vld;
  logic [LINK_W-1:0]       link_data;
  logic                    link_vld;
  logic                    link_rdy;
  logic                    link_sof;
  logic                    link_eof;
  logic                    overflow;
  logic [CNT_W-1:0]        drop_cnt;
  logic [$clog2(DEPTH):0]  fifo_level;

  flit_link_serializer #(
    .FLIT_W(FLIT_W), .LINK_W(LINK_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .flit_in(flit_in), .flit_in_vld(flit_in_vld),
    .link_data(link_data), .link_vld(link_vld), .link_rdy(link_rdy),
    .link_sof(link_sof), .link_eof(link_eof),
    .overflow(overflow), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [LINK_W-1:0] d;
    logic              s;
    logic              e;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  int    m_level;
  int    m_rem;
  bit    m_ovf;
  int    m_cnt;
  bit    m_full;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Reference: FIFO count plus beats left on the flit being sent.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_level = 0;
      m_rem   = 0;
      m_ovf   = 0;
      m_cnt   = 0;
      exp_q.delete();
    end else begin
      m_full = (m_level == DEPTH);
      if (m_rem == 0) begin
        if (m_level > 0) begin
          m_level--;
          m_rem = BEATS;
        end
      end else if (link_rdy) begin
        m_rem--;
        if (m_rem == 0 && m_level > 0) begin
          m_level--;
          m_rem = BEATS;
        end
      end
      m_ovf = flit_in_vld && m_full;
      if (m_ovf && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (flit_in_vld && !m_full) begin
        m_level++;
        for (int i = 0; i < BEATS; i++) begin
          beat_t b;
          b.d = LINK_W'(flit_in >> ((BEATS - 1 - i) * LINK_W));
          b.s = (i == 0);
          b.e = (i == BEATS - 1);
          exp_q.push_back(b);
        end
      end
    end
  end

  bit                p_stall = 0;
  logic [LINK_W-1:0] p_data;
  logic              p_sof;
  logic              p_eof;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_vld", link_vld, 0);
      chk("rst_data", link_data, 0);
      chk("rst_sofeof", {link_sof, link_eof}, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_cnt", drop_cnt, 0);
      chk("rst_level", fifo_level, 0);
      p_stall = 0;
    end else begin
      chk("vld", link_vld, m_rem > 0);
      chk("level", fifo_level, m_level);
      chk("ovf", overflow, m_ovf);
      chk("cnt", drop_cnt, m_cnt);
      if (p_stall) begin
        chk("stall_data", link_data, p_data);
        chk("stall_sofeof", {link_sof, link_eof}, {p_sof, p_eof});
      end
      if (link_vld && link_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_data", link_data, b.d);
          chk("beat_sofeof", {link_sof, link_eof}, {b.s, b.e});
        end
      end
      p_stall = link_vld && !link_rdy;
      p_data  = link_data;
      p_sof   = link_sof;
      p_eof   = link_eof;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FLIT_W-1:0] f);
    flit_in     = f;
    flit_in_vld = 1'b1;
    tick();
    flit_in_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    flit_in_vld = 1'b0;
    link_rdy    = 1'b1;
    n = 0;
    while ((m_rem != 0 || m_level != 0 || exp_q.size() != 0) && n < 1000) begin
      tick();
      n++;
    end
    chk("drain_timeout", n >= 1000, 0);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [FLIT_W-1:0] rnd_flit();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [FLIT_W-1:0] f0;
    flit_in     = '0;
    flit_in_vld = 1'b0;
    link_rdy    = 1'b1;
    rst_n       = 1'b0;
    #1;
    chk("reset_vld_async", link_vld, 0);
    tick();
    do_reset();

    // single flit, latency and word order
    f0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    send(f0);
    chk("t1_level", fifo_level, 1);
    chk("t1_vld_early", link_vld, 0);
    tick();
    chk("t1_vld", link_vld, 1);
    chk("t1_beat0", {link_sof, link_data}, {1'b1, 32'h00112233});
    tick();
    tick();
    tick();
    chk("t1_beat3", {link_eof, link_data}, {1'b1, 32'hCCDDEEFF});
    tick();
    chk("t1_vld_end", link_vld, 0);
    drain();

    // three back-to-back flits
    for (int i = 0; i < 3; i++) send(rnd_flit());
    drain();
    chk("t2_cnt", drop_cnt, 0);

    // stall, fill, drop; then drop on a final-beat pop edge
    do_reset();
    link_rdy = 1'b0;
    for (int i = 0; i < 6; i++) send(rnd_flit());
    chk("t3_level", fifo_level, DEPTH);
    chk("t3_ovf", overflow, 1);
    chk("t3_cnt", drop_cnt, 1);
    link_rdy = 1'b1;
    tick();
    chk("t3_ovf_pulse", overflow, 0);
    tick();
    tick();
    chk("t4_eof", link_eof, 1);
    send(rnd_flit());
    chk("t4_ovf", overflow, 1);
    chk("t4_cnt", drop_cnt, 2);
    chk("t4_level", fifo_level, DEPTH - 1);
    drain();

    // random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      flit_in     = rnd_flit();
      flit_in_vld = ($urandom_range(0, 2) == 0);
      link_rdy    = $urandom_range(0, 1);
      tick();
    end
    drain();

    // reset mid-burst with flits queued
    do_reset();
    link_rdy = 1'b1;
    for (int i = 0; i < 3; i++) send(rnd_flit());
    tick();
    chk("t6_mid_burst", link_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_vld", link_vld, 0);
    chk("t6_async_data", link_data, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("t6_quiet", link_vld, 0);
    f0 = rnd_flit();
    send(f0);
    tick();
    chk("t6_fresh", {link_sof, link_data}, {1'b1, f0[FLIT_W-1 -: LINK_W]});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flit_link_serializer.md
# flit_link_serializer

Downstream stage of the shape-changeable chip's outbound flit port. Captures 128-bit flits from `flit_tx`/`flit_tx_vld`, which carry no backpressure, into a small FIFO. Emits each flit as a burst of 32-bit beats on a narrow inter-chip link with a valid/ready handshake. Flits that arrive while the FIFO is full are dropped, flagged and counted.

## Interface
- `FLIT_W`, 128: flit width; must be an integer multiple of `LINK_W`.
- `LINK_W`, 32: link beat width. `BEATS = FLIT_W/LINK_W`, must be ≥ 2.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16: drop counter width.

- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `flit_in` in `FLIT_W`: flit from the chip's `flit_tx`.
- `flit_in_vld` in 1: flit valid; one flit per high cycle; no ready.
- `link_data` out `LINK_W`: current beat.
- `link_vld` out 1: beat valid.
- `link_rdy` in 1: link accepts beat.
- `link_sof` out 1: high with the first beat of a flit.
- `link_eof` out 1: high with the last beat of a flit.
- `overflow` out 1: one-cycle pulse when an incoming flit is dropped.
- `drop_cnt` out `CNT_W`: saturating count of dropped flits.
- `fifo_level` out `$clog2(DEPTH)+1`: current FIFO occupancy (0..`DEPTH`).

## Operation
- FIFO uses read/write pointers of `$clog2(DEPTH)+1` bits. Full and empty are derived from pointer MSB and index comparison.
- Write: on a `clk` edge with `flit_in_vld`=1 and FIFO not full, store `flit_in` and advance the write pointer.
- Drop: `flit_in_vld`=1 while full. Nothing is written. Next cycle `overflow`=1, and `drop_cnt` increments unless it is at all-ones (it saturates).
- Fullness is judged on the registered state before the edge. A pop on the same edge does not rescue the incoming flit; it is still dropped.
- Serializer FSM, two states:
  - IDLE: `link_vld`=0. If FIFO is non-empty: pop the head into a `FLIT_W` shift register, set beat index to 0, go to SEND.
  - SEND: `link_vld`=1. `link_data` = shift register bits [`FLIT_W-1` : `FLIT_W-LINK_W`], so the most significant word goes first. `link_sof` = (beat==0); `link_eof` = (beat==`BEATS-1`).
  - SEND, on `link_vld && link_rdy` with beat < `BEATS-1`: shift left by `LINK_W`, beat+1.
  - SEND, on the handshake with beat = `BEATS-1`: if FIFO is non-empty, pop the next flit into the shift register, set beat to 0, and stay in SEND (no bubble). Otherwise go to IDLE.
- Total buffering is `DEPTH` FIFO entries plus the flit held in the shift register.
- Push and pop on the same edge: both take effect, and `fifo_level` is unchanged.
- Flit order is preserved. Beats of different flits never interleave.

## Timing
- Reset values: `link_vld`, `link_sof`, `link_eof`, `overflow` = 0; `link_data` = 0; `drop_cnt` = 0; `fifo_level` = 0; FSM = IDLE; pointers = 0.
- Reset asserted mid-burst aborts the flit immediately. No further beats or sof/eof are emitted. All queued flits are discarded.
- Latency: with the FIFO empty and FSM in IDLE, a flit sampled at edge 0 gives `fifo_level`=1 after edge 0. IDLE pops at edge 1. Beat 0 appears with `link_vld`=1 after edge 1, so two cycles from input.
- While `link_vld`=1 and `link_rdy`=0, `link_data`, `link_sof` and `link_eof` hold stable.
- With `link_rdy` held at 1, throughput is one flit per `BEATS` cycles, and consecutive flits are back-to-back.
- All outputs are registered or decoded from registered state only. No combinational path from `link_rdy` to `link_vld` or `link_data`.

## Test plan
- Single flit 0x00112233_44556677_8899AABB_CCDDEEFF with `link_rdy`=1 -> `link_vld` rises 2 cycles later. Beats are 0x00112233 (sof), 0x44556677, 0x8899AABB, 0xCCDDEEFF (eof). `link_vld` is 0 the next cycle.
- Three flits on consecutive cycles with `link_rdy`=1 -> 12 contiguous beats in order, sof on beats 0/4/8, eof on beats 3/7/11. `drop_cnt`=0.
- `link_rdy` held 0, then 6 consecutive flits -> first flit in the shift register, 4 in the FIFO (`fifo_level`=4), the 6th dropped. `overflow` pulses once, `drop_cnt`=1. Release `link_rdy` -> exactly 5 flits emitted, in order.
- Random `link_rdy` toggling (50%) -> `link_data`/sof/eof stable across every stall cycle. Scoreboard matches every accepted flit.
- With FIFO full, input flit arrives on the same edge as a final-beat pop -> the flit is dropped, `drop_cnt` increments, and `fifo_level` goes to `DEPTH-1`.
- `rst_n` pulsed low during beat 2 of a flit with 2 more queued -> outputs go to 0 immediately and no residual beats follow. A fresh flit after reset serializes correctly starting with sof.
